// File: rtl/sensor_frame_rx.sv
// sensor_frame_rx: reassembles header/ID/32-bit data frames from UART byte strobes into {id, data} words.
// Optional trailing checksum byte and its check are built when SENSOR_FRAME_CHKSUM_EN is defined.
module sensor_frame_rx #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         ID_NUM      = 8,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_byte_f,
    input  logic [7:0]  rx_byte,
    output logic        store_data_f,
    output logic [39:0] store_data,
    output logic        err_f,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef SENSOR_FRAME_CHKSUM_EN
    localparam int DW = 32;
    typedef enum logic [1:0] {IDLE, GET_ID, GET_DATA, GET_CHK} state_t;
    logic [7:0] acc;
`else
    localparam int DW = 24;
    typedef enum logic [1:0] {IDLE, GET_ID, GET_DATA} state_t;
`endif
    state_t state, state_nxt;
    logic [7:0] id;
    logic [DW-1:0] data;
    logic [1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic fin, tmo, bad_id, chk_bad, ok_go, err_go;
    logic [39:0] word;
    logic [1:0] code;
    assign tmo = state != IDLE && !rx_byte_f && tcnt == TW'(TIMEOUT_CYC - 1);
    assign bad_id = {1'b0, id} >= 9'(ID_NUM);
`ifdef SENSOR_FRAME_CHKSUM_EN
    assign word = {id, data};
    assign chk_bad = rx_byte != acc;
`else
    // the 4th data byte is still on rx_byte when the frame is evaluated
    assign word = {id, data, rx_byte};
    assign chk_bad = 1'b0;
`endif
    assign ok_go = fin & ~bad_id & ~chk_bad;
    assign err_go = tmo | (fin & (bad_id | chk_bad));
    assign code = tmo ? 2'b10 : bad_id ? 2'b11 : 2'b01;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin = 1'b0;
        if (tmo) state_nxt = IDLE;
        else if (rx_byte_f)
            case (state)
                IDLE: state_nxt = rx_byte == HEADER ? GET_ID : IDLE;
                GET_ID: state_nxt = GET_DATA;
`ifdef SENSOR_FRAME_CHKSUM_EN
                GET_DATA: state_nxt = bcnt == 2'd3 ? GET_CHK : GET_DATA;
                GET_CHK: begin
                    fin = 1'b1;
                    state_nxt = IDLE;
                end
`else
                GET_DATA: begin
                    fin = bcnt == 2'd3;
                    state_nxt = fin ? IDLE : GET_DATA;
                end
`endif
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            store_data_f <= 1'b0;
            store_data <= '0;
            err_f <= 1'b0;
            err_code <= '0;
            err_cnt <= '0;
            id <= '0;
            data <= '0;
            bcnt <= '0;
            tcnt <= '0;
`ifdef SENSOR_FRAME_CHKSUM_EN
            acc <= '0;
`endif
        end else begin
            store_data_f <= ok_go;
            err_f <= err_go;
            if (ok_go) store_data <= word;
            if (err_go) begin
                err_code <= code;
                err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
            end
            tcnt <= (state == IDLE || rx_byte_f) ? '0 : tcnt + 1'b1;
            if (rx_byte_f && state == GET_ID) begin
                id <= rx_byte;
                bcnt <= '0;
            end
            if (rx_byte_f && state == GET_DATA) begin
                data <= {data[DW-9:0], rx_byte};
                bcnt <= bcnt + 1'b1;
            end
`ifdef SENSOR_FRAME_CHKSUM_EN
            if (state == IDLE) acc <= '0;
            else if (rx_byte_f && state != GET_CHK) acc <= acc + rx_byte;
`endif
        end
    end
endmodule
